// File: rtl/decoder_pkg.sv
// Shared defaults and helpers for the pipelined one-hot index decoder.
package decoder_pkg;
  localparam int DEF_N  = 5;
  localparam int DEF_LO = 3;

  function automatic int out_width(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/decoder_if.sv
// Request/response handshake bundle for decoder_pipelined.
interface decoder_if
  import decoder_pkg::*;
#(
  parameter int N = DEF_N
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    ena;
  logic [N-1:0]            in;
  logic                    out_valid;
  logic                    out_ready;
  logic [out_width(N)-1:0] out;
  logic                    busy;

  modport master (
    output in_valid, ena, in, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, ena, in, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/decoder_stage.sv
// Combinational M-to-2**M one-hot decode with enable; all-zero when disabled.
module decoder_stage #(
  parameter int M = 2
) (
  input  logic              ena,
  input  logic [M-1:0]      in,
  output logic [(1<<M)-1:0] out
);
  always_comb begin
    out = '0;
    for (int i = 0; i < (1 << M); i++) out[i] = ena && (in == M'(i));
  end
endmodule

// File: rtl/decoder_pipelined.sv
// Two-stage valid/ready one-hot decoder: stage 1 decodes the upper index bits
// into a group select, stage 2 expands it with the low bits.
// Optional macro DECODER_ZERO_MASK_EN forces out[0] to 0.
module decoder_pipelined
  import decoder_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int LO = DEF_LO
) (
  input  logic     clk,
  input  logic     rst_n,
  decoder_if.slave bus
);
  localparam int HI = N - LO;
  localparam int G  = 1 << HI;
  localparam int L  = 1 << LO;
  localparam int W  = out_width(N);

  logic          s1_valid;
  logic [G-1:0]  grp;
  logic [LO-1:0] lo;
  logic          out_valid;
  logic [W-1:0]  out_q;

  logic          adv1, adv2, accept;
  logic [G-1:0]  grp_dec;
  logic [L-1:0]  lo_dec;
  logic [W-1:0]  out_dec;
  logic [W-1:0]  out_word;

  assign adv2   = !out_valid || bus.out_ready;
  assign adv1   = !s1_valid || adv2;
  assign accept = bus.in_valid && adv1;

  decoder_stage #(.M(HI)) u_grp (
    .ena (bus.ena),
    .in  (bus.in[N-1:LO]),
    .out (grp_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      grp      <= '0;
      lo       <= '0;
    end else begin
      if (adv1) s1_valid <= bus.in_valid;
      if (accept) begin
        grp <= grp_dec;
        lo  <= bus.in[LO-1:0];
      end
    end
  end

  // ena is already folded into grp, so the low decode is always enabled
  decoder_stage #(.M(LO)) u_lo (
    .ena (1'b1),
    .in  (lo),
    .out (lo_dec)
  );

  for (genvar g = 0; g < G; g++) begin : g_grp
    assign out_dec[g*L +: L] = grp[g] ? lo_dec : '0;
  end

`ifdef DECODER_ZERO_MASK_EN
  assign out_word = {out_dec[W-1:1], 1'b0};
`else
  assign out_word = out_dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) out_q <= out_word;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_q;
  assign bus.busy      = s1_valid || out_valid;
endmodule

// File: tb/tb_decoder_pipelined.sv
// Bench for decoder_pipelined: directed scenarios on the default build plus
// randomized traffic on three parameter sets against a queue-based model.
module tb_decoder_pipelined;
  logic clk;
  logic rst_n;
  logic mon_en;

  logic [2:0]   iv, en, ordy;
  logic [7:0]   in_t [3];
  logic [2:0]   ir, ov, bz;
  logic [255:0] out_t [3];

  int passed = 0;
  int total  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // what the decoder must emit: ena ? 1<<idx : 0, with bit 0 masked when configured
  function automatic logic [255:0] exp_word(input logic e, input int idx);
    logic [255:0] w;
    w = e ? (256'(1) << idx) : '0;
`ifdef DECODER_ZERO_MASK_EN
    w[0] = 1'b0;
`endif
    return w;
  endfunction

  function automatic int cfg_n(input int k);
    return (k == 0) ? 5 : (k == 1) ? 3 : 8;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_cfg
    localparam int SN = (k == 0) ? 5 : (k == 1) ? 3 : 8;
    localparam int SL = (k == 0) ? 3 : (k == 1) ? 1 : 4;

    decoder_if #(.N(SN)) bus ();

    decoder_pipelined #(.N(SN), .LO(SL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.in_valid  = iv[k];
    assign bus.ena       = en[k];
    assign bus.in        = in_t[k][SN-1:0];
    assign bus.out_ready = ordy[k];
    assign ir[k]         = bus.in_ready;
    assign ov[k]         = bus.out_valid;
    assign bz[k]         = bus.busy;
    assign out_t[k]      = 256'(bus.out);

    // queue holds every accepted request not yet taken by the consumer
    logic [255:0] q [$];
    logic [255:0] prev_out;
    logic         prev_stall;

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
      end else if (mon_en) begin
        chkb($sformatf("busy[%0d]", k), bz[k], q.size() != 0);
        chkb($sformatf("in_ready[%0d]", k), ir[k], !(q.size() == 2 && !ordy[k]));
        chkb($sformatf("onehot[%0d]", k), $countones(out_t[k]) <= 1, 1'b1);
        if (prev_stall) begin
          chkb($sformatf("stall_valid[%0d]", k), ov[k], 1'b1);
          chk($sformatf("stall_out[%0d]", k), out_t[k], prev_out);
        end
        if (q.size() == 0) chkb($sformatf("no_phantom[%0d]", k), ov[k], 1'b0);
        else if (ov[k]) begin
          chk($sformatf("order_out[%0d]", k), out_t[k], q[0]);
          if (ordy[k]) void'(q.pop_front());
        end
        prev_stall = ov[k] && !ordy[k];
        prev_out   = out_t[k];
        if (iv[k] && ir[k]) q.push_back(exp_word(en[k], int'(in_t[k])));
      end
    end
  end

  task automatic rand_run(input int k, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      iv[k]   = ($urandom % 4) != 0;
      en[k]   = ($urandom % 5) != 0;
      in_t[k] = 8'($urandom_range((1 << cfg_n(k)) - 1, 0));
      ordy[k] = ($urandom % 3) != 0;
    end
    @(posedge clk); #1;
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] drain_exp [3];
    int got, seen;
    drain_exp[0] = 256'h80;
    drain_exp[1] = 256'h200;
    drain_exp[2] = 256'h800;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    iv = '0; en = '0; ordy = '0;
    for (int k = 0; k < 3; k++) in_t[k] = '0;

    repeat (2) @(negedge clk);
    chkb("rst_out_valid", ov[0], 1'b0);
    chk("rst_out", out_t[0], '0);
    chkb("rst_busy", bz[0], 1'b0);
    chkb("rst_in_ready", ir[0], 1'b1);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // single request, latency two
    @(posedge clk); #1;
    iv[0] = 1'b1; en[0] = 1'b1; in_t[0] = 8'd19; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chkb("lat1_valid", ov[0], 1'b0);
    @(posedge clk); #1;
    chkb("lat2_valid", ov[0], 1'b1);
    chk("lat2_out", out_t[0], 256'h0008_0000);
    @(posedge clk); #1;
    chkb("lat3_valid", ov[0], 1'b0);

    // back-to-back sweep of every index
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      iv[0]   = (i < 32);
      in_t[0] = 8'(i % 32);
      @(negedge clk);
      chkb("b2b_valid", ov[0], (i >= 2 && i < 34));
      if (i >= 2 && i < 34) chk("b2b_out", out_t[0], exp_word(1'b1, i - 2));
    end

    // back-pressure: fill both stages, hold, then release
    @(posedge clk); #1;
    ordy[0] = 1'b0; iv[0] = 1'b1; en[0] = 1'b1; in_t[0] = 8'd7;
    @(posedge clk); #1;
    in_t[0] = 8'd9;
    @(posedge clk); #1;
    in_t[0] = 8'd11;
    @(negedge clk);
    chkb("full_in_ready", ir[0], 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chkb("hold_valid", ov[0], 1'b1);
      chk("hold_out", out_t[0], 256'h80);
      chkb("hold_in_ready", ir[0], 1'b0);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        chk("drain_out", out_t[0], drain_exp[got]);
        got++;
      end
      @(posedge clk); #1;
      iv[0] = 1'b0;
    end
    chki("drain_count", got, 3);

    // ena=0 yields a valid all-zero word
    @(posedge clk); #1;
    iv[0] = 1'b1; en[0] = 1'b0; in_t[0] = 8'd31;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        seen = 1;
        chk("ena0_out", out_t[0], '0);
      end
    end
    chki("ena0_seen", seen, 1);

    // reset while a request is in flight discards it
    repeat (3) @(posedge clk);
    #1;
    iv[0] = 1'b1; en[0] = 1'b1; in_t[0] = 8'd3;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #2;
    chkb("pre_rst_valid", ov[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("async_rst_valid", ov[0], 1'b0);
    chk("async_rst_out", out_t[0], '0);
    chkb("async_rst_busy", bz[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chki("post_rst_emitted", seen, 0);

    // randomized traffic with stalls on all three parameter sets
    fork
      rand_run(0, 500);
      rand_run(1, 500);
      rand_run(2, 500);
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chkb($sformatf("final_idle[%0d]", k), bz[k], 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decoder_pipelined.md
DECODER_PIPELINED -- requirements
Module: decoder_pipelined

Interface
REQ-001 Parameter N, default 5, input index width; legal range 2..8.
REQ-002 Parameter LO, default 3, low index bits decoded in stage 2; legal range 1..N-1.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request present on ena/in.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 ena  input  1  decode enable; 0 yields an all-zero result.
REQ-008 in  input  N  index to decode.
REQ-009 out_valid  output  1  out holds a valid decoded word.
REQ-010 out_ready  input  1  consumer takes out this cycle.
REQ-011 out  output  2**N  one-hot decoded word, registered.
REQ-012 busy  output  1  high when either pipeline stage holds a valid entry.

Function
REQ-013 A request SHALL be accepted on a cycle where in_valid && in_ready.
REQ-014 Stage 1 SHALL register: upper one-hot group select grp[2**(N-LO)-1:0] = decode(in[N-1:LO]) gated by ena, raw lo = in[LO-1:0], and s1_valid.
REQ-015 Stage 2 SHALL register out[g*2**LO + l] = grp[g] && (l == lo), i.e. out = ena ? (1 << in) : 0.
REQ-016 Latency SHALL be exactly 2 cycles from acceptance to out_valid with out_ready held high.
REQ-017 Throughput SHALL be one request per cycle with out_ready held high; no bubbles.
REQ-018 Stage 2 advances when !out_valid || out_ready; stage 1 advances when !s1_valid || stage 2 advances.
REQ-019 in_ready SHALL equal !s1_valid || stage-2 advance (combinational, no dependence on in_valid).
REQ-020 While out_valid && !out_ready, out and out_valid SHALL hold stable.
REQ-021 Accepted request with ena=0 SHALL produce out_valid=1, out=0.
REQ-022 out SHALL have at most one bit set at all times.
REQ-023 Index wrap: in = 2**N-1 SHALL set only the MSB of out; in = 0 only bit 0 (subject to REQ-027).
REQ-024 Full pipeline (both stages valid) with out_ready=0 SHALL drive in_ready=0; no request is dropped or duplicated.
REQ-025 Simultaneous out_ready and acceptance with full pipeline SHALL shift both stages in one cycle.

Reset
REQ-026 rst_n low SHALL asynchronously clear s1_valid, out_valid, grp, lo, out to 0; busy=0, in_ready=1 after release; in-flight requests are discarded.

Configuration
REQ-027 Macro DECODER_ZERO_MASK_EN defined: out[0] SHALL be forced 0 (register x0 write suppression); out_valid still asserts for in=0. Undefined: out[0] decodes normally.

Structure
REQ-028 Package decoder_pkg SHALL hold default N, default LO and a function/constant for output width 2**N.
REQ-029 Sub-module decoder_stage (combinational, parameter M, ena, M-bit in, 2**M one-hot out) SHALL be instantiated for the stage-1 group decode and the stage-2 low decode.

Verification
REQ-030 Reset, then in_valid=1, ena=1, in=5'd19, out_ready=1 -> two cycles later out_valid=1, out=32'h0008_0000, then out_valid=0.
REQ-031 Back-to-back in=0..31, ena=1, out_ready=1 -> out_valid high 32 consecutive cycles, out=1<<i in order (bit 0 zero when DECODER_ZERO_MASK_EN).
REQ-032 Accept in=7, in=9, in=11 with out_ready=0 -> in_ready drops after 2 accepts; out=32'h80 holds; release out_ready -> 32'h80, 32'h200, 32'h800 in order, none lost.
REQ-033 in_valid=1, ena=0, in=5'd31 -> out_valid=1, out=32'h0.
REQ-034 Accept in=3, assert rst_n=0 one cycle later -> out_valid=0, out=0 immediately; after release, nothing emitted.
REQ-035 Parameter sweep N=3/LO=1 and N=8/LO=4 -> out == (ena << in) for random in with random out_ready stalls, scoreboard order-checked.
